rwl_pulse_ctrl: RTL and testbench



---
 rtl/rwl_pkg.sv | 15 +
 rtl/rwl_onehot_dec.sv | 22 ++
 rtl/rwl_pulse_ctrl.sv | 107 ++++++++++
 tb/tb_rwl_pulse_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rwl_pkg.sv
// Shared types and default geometry for the read-wordline pulse controller.
package rwl_pkg;

  localparam int ROWS_DEF = 16;
  localparam int AW_DEF   = 4;
  localparam int PWW_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GUARD = 2'd3
  } rwl_state_e;

endpackage

// File: rtl/rwl_onehot_dec.sv
// Combinational row decoder: one-hot select when enabled, plus an out-of-range flag.
module rwl_onehot_dec #(
  parameter int ROWS = 16,
  parameter int AW   = 4
) (
  input  logic            en_i,
  input  logic [AW-1:0]   addr_i,
  output logic [ROWS-1:0] onehot_o,
  output logic            oor_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (en_i && (addr_i == AW'(i))) onehot_o[i] = 1'b1;
    end
  end

  // One extra bit so ROWS == 2**AW still compares correctly.
  assign oor_o = ({1'b0, addr_i} >= (AW + 1)'(ROWS));

endmodule

// File: rtl/rwl_pulse_ctrl.sv
// Read-wordline pulse controller: REQ/ACK front end, precharge sequencing and a
// registered one-hot wordline pulse of PW+1 cycles.
//
//   state | meaning
//   IDLE  | precharge on, wordlines low, waiting for REQ
//   SETUP | precharge released, wordlines still low (1 cycle)
//   PULSE | selected wordline high for PW+1 cycles
//   GUARD | wordlines low, precharge back on, ACK/ERR presented (1 cycle)
module rwl_pulse_ctrl
  import rwl_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = AW_DEF,
  parameter int PWW  = PWW_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ,
  input  logic [AW-1:0]   ADDR,
  input  logic [PWW-1:0]  PW,
  output logic            ACK,
  output logic            ERR,
  output logic            BUSY,
  output logic            RBL_PRE,
  output logic [ROWS-1:0] RWL
);

  rwl_state_e      state_q;
  logic [AW-1:0]   addr_q;
  logic [PWW-1:0]  pw_q;
  logic [PWW-1:0]  cnt_q;
  logic [ROWS-1:0] rwl_q;
  logic            ack_q;
  logic            err_q;
  logic            busy_q;
  logic            pre_q;

  logic [ROWS-1:0] dec_rwl;
  logic            dec_oor;

  rwl_onehot_dec #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_dec (
    .en_i     (state_q == SETUP),
    .addr_i   (addr_q),
    .onehot_o (dec_rwl),
    .oor_o    (dec_oor)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pw_q    <= '0;
      cnt_q   <= '0;
      rwl_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            addr_q  <= ADDR;
            pw_q    <= PW;
            pre_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // Decoder is enabled only here, so RWL is loaded once and held.
          rwl_q   <= dec_rwl;
          cnt_q   <= pw_q;
          state_q <= PULSE;
        end
        PULSE: begin
          if (cnt_q == '0) begin
            rwl_q   <= '0;
            pre_q   <= 1'b1;
            ack_q   <= 1'b1;
            err_q   <= dec_oor;
            state_q <= GUARD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GUARD: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ACK     = ack_q;
  assign ERR     = err_q;
  assign BUSY    = busy_q;
  assign RBL_PRE = pre_q;
  assign RWL     = rwl_q;

endmodule

// File: tb/tb_rwl_pulse_ctrl.sv
// Scoreboard bench: 16-row and 12-row controllers driven in lockstep from one
// request stream; a monitor checks each pulse and ACK against expected records.
module tb_rwl_pulse_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ = 1'b0;
  logic [3:0]  ADDR = '0;
  logic [2:0]  PW = '0;

  logic        ACK16, ERR16, BUSY16, PRE16;
  logic [15:0] RWL16;
  logic        ACK12, ERR12, BUSY12, PRE12;
  logic [11:0] RWL12;

  rwl_pulse_ctrl #(.ROWS(16), .AW(4), .PWW(3)) u16 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .ADDR(ADDR), .PW(PW),
    .ACK(ACK16), .ERR(ERR16), .BUSY(BUSY16), .RBL_PRE(PRE16), .RWL(RWL16)
  );

  rwl_pulse_ctrl #(.ROWS(12), .AW(4), .PWW(3)) u12 (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .ADDR(ADDR), .PW(PW),
    .ACK(ACK12), .ERR(ERR12), .BUSY(BUSY12), .RBL_PRE(PRE12), .RWL(RWL12)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          e;      // index of the accepting clock edge
    int          pw;
    logic [15:0] word [2];
    logic        err  [2];
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] rwl_v [2];
  logic [1:0]  pre_v, ack_v, err_v, busy_v;
  always_comb begin
    rwl_v[0] = RWL16;
    rwl_v[1] = {4'b0, RWL12};
    pre_v  = {PRE12, PRE16};
    ack_v  = {ACK12, ACK16};
    err_v  = {ERR12, ERR16};
    busy_v = {BUSY12, BUSY16};
  end

  int          len [2];
  int          first [2];
  int          prelow [2];
  bit          ended [2];
  logic [15:0] word [2];
  bit          post_ack;

  always @(negedge CLK) begin
    exp_t x;
    if (!RST_N) begin
      for (int d = 0; d < 2; d++) begin
        len[d] = 0; prelow[d] = 0; ended[d] = 0; word[d] = '0; first[d] = 0;
      end
      post_ack = 0;
    end else begin
      if (post_ack) begin
        chk("busy_after_guard", int'(busy_v), 0);
        post_ack = 0;
      end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("onehot%0d", d), int'($countones(rwl_v[d]) <= 1), 1);
        chk($sformatf("rwl_while_pre%0d", d), int'(rwl_v[d] != 0 && pre_v[d]), 0);
        if (!pre_v[d]) prelow[d]++;
        if (rwl_v[d] != 0) begin
          if (ended[d]) chk($sformatf("single_pulse%0d", d), 1, 0);
          if (len[d] == 0) begin
            first[d] = cyc;
            word[d]  = rwl_v[d];
          end else if (rwl_v[d] != word[d]) begin
            chk($sformatf("rwl_stable%0d", d), int'(rwl_v[d]), int'(word[d]));
          end
          len[d]++;
        end else if (len[d] != 0) begin
          ended[d] = 1;
        end
      end
      if (ack_v != 2'b00) begin
        chk("ack_lockstep", int'(ack_v), 3);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          x = sb.pop_front();
          // ACK is visible in the cycle after edge accept+PW+2
          chk("ack_latency", cyc - x.e, x.pw + 2);
          for (int d = 0; d < 2; d++) begin
            chk($sformatf("err%0d", d), int'(err_v[d]), int'(x.err[d]));
            chk($sformatf("busy_at_ack%0d", d), int'(busy_v[d]), 1);
            chk($sformatf("rwl_word%0d", d), int'(word[d]), int'(x.word[d]));
            chk($sformatf("rwl_len%0d", d), len[d], (x.word[d] != 0) ? x.pw + 1 : 0);
            if (x.word[d] != 0) chk($sformatf("rwl_start%0d", d), first[d] - x.e, 1);
            chk($sformatf("pre_low%0d", d), prelow[d], x.pw + 2);
            len[d] = 0; prelow[d] = 0; ended[d] = 0; word[d] = '0;
          end
        end
        post_ack = 1;
      end
    end
  end

  // ---------------- driver ----------------
  int prev_e = 0;
  int prev_pw = 0;
  bit prev_keep = 0;

  task automatic issue(input int addr, input int pw, input bit keep);
    int   guard = 0;
    exp_t x;
    @(negedge CLK);
    while (BUSY16 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 200) begin
      chk("accept_timeout", 1, 0);
      return;
    end
    if (!REQ) repeat ($urandom_range(0, 2)) @(negedge CLK);
    REQ  = 1'b1;
    ADDR = 4'(addr);
    PW   = 3'(pw);
    x.e  = cyc + 1;
    if (prev_keep) chk("req_spacing", x.e - prev_e, prev_pw + 4);
    x.pw      = pw;
    x.word[0] = 16'(1) << addr;
    x.err[0]  = 1'b0;
    x.word[1] = (addr < 12) ? (16'(1) << addr) : 16'h0000;
    x.err[1]  = (addr >= 12);
    sb.push_back(x);
    prev_e = x.e; prev_pw = pw; prev_keep = keep;
    @(negedge CLK);
    if (!keep) REQ = 1'b0;
    ADDR = 4'($urandom);
    PW   = 3'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int guard;
    repeat (3) @(negedge CLK);
    chk("rst_rwl16", int'(RWL16), 0);
    chk("rst_pre16", int'(PRE16), 1);
    chk("rst_ack_err", int'({ACK16, ERR16, ACK12, ERR12}), 0);
    #1 RST_N = 1'b1;
    repeat (8) begin
      @(negedge CLK);
      chk("idle_rwl", int'(RWL16) | int'(RWL12), 0);
      chk("idle_pre", int'({PRE16, PRE12}), 3);
      chk("idle_busy_ack", int'({BUSY16, ACK16, BUSY12, ACK12}), 0);
    end

    issue(5, 0, 0);
    issue(15, 7, 0);
    issue(3, 2, 1);
    issue(9, 2, 0);
    issue(13, 4, 0);

    // Reset in the middle of a pulse on row 2.
    issue(2, 7, 0);
    @(negedge CLK);
    chk("pulse_before_rst", int'(RWL16), 16'h0004);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_async_rwl", int'(RWL16) | int'(RWL12), 0);
    chk("rst_async_busy_ack", int'({BUSY16, ACK16, BUSY12, ACK12}), 0);
    chk("rst_async_pre", int'({PRE16, PRE12}), 3);
    sb.delete();
    @(negedge CLK);
    #1 RST_N = 1'b1;
    prev_keep = 0;

    issue(6, 1, 0);
    for (int i = 0; i < 40; i++)
      issue($urandom_range(0, 15), $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
    REQ = 1'b0;

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    repeat (3) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
